// File: rtl/mult_arbiter_pkg.sv
// Shared constants and FSM encoding for the multiplier-sharing arbiter family.
package mult_arbiter_pkg;

    localparam int DEF_N = 2;
    localparam int DEF_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester-side and multiplier-side signals of the arbiter, bundled as one interface.
interface mult_arbiter_if #(
    parameter int N = mult_arbiter_pkg::DEF_N,
    parameter int W = mult_arbiter_pkg::DEF_W
) ();

    logic [N-1:0]   req;
    logic [N*W-1:0] a_flat;
    logic [N*W-1:0] b_flat;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [2*W-1:0] y;
    logic           busy;
    logic           mul_start;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic           mul_busy;
    logic [2*W-1:0] mul_y;

    // master: the arbiter itself; slave: requesters plus the external multiplier
    modport master (
        input  req, a_flat, b_flat, mul_busy, mul_y,
        output gnt, done, y, busy, mul_start, mul_a, mul_b
    );

    modport slave (
        output req, a_flat, b_flat, mul_busy, mul_y,
        input  gnt, done, y, busy, mul_start, mul_a, mul_b
    );

endinterface

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational round-robin select: first set request after i_last, wrapping modulo N.
module mult_arbiter_rr_pick #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [IW-1:0] o_winner,
    output logic          o_valid
);

    localparam int IW1 = IW + 1;

    logic [IW-1:0] w_cand [N];

    // w_cand[gi] is the requester gi+1 places after the last grant
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            logic [IW:0] w_sum;
            assign w_sum       = {1'b0, i_last} + IW1'(gi + 1);
            assign w_cand[gi]  = (w_sum >= IW1'(N)) ? IW'(w_sum - IW1'(N)) : w_sum[IW-1:0];
        end
    endgenerate

    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[w_cand[k]]) begin
                o_winner = w_cand[k];
                o_valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one external multiplier among N requesters.
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_arbiter_if.master bus
);

    localparam int IW = $clog2(N);

    arb_state_t     r_state;
    arb_state_t     w_state_next;
    logic [IW-1:0]  r_last,  w_last_next;
    logic [N-1:0]   r_gnt,   w_gnt_next;
    logic [N-1:0]   r_done,  w_done_next;
    logic [2*W-1:0] r_y,     w_y_next;
    logic           r_busy,  w_busy_next;
    logic           r_start, w_start_next;
    logic [W-1:0]   r_mul_a, w_mul_a_next;
    logic [W-1:0]   r_mul_b, w_mul_b_next;

    logic [IW-1:0]  w_winner;
    logic           w_pick_valid;
    logic [W-1:0]   w_a [N];
    logic [W-1:0]   w_b [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign w_a[gi] = bus.a_flat[gi*W +: W];
            assign w_b[gi] = bus.b_flat[gi*W +: W];
        end
    endgenerate

    mult_arbiter_rr_pick #(.N(N), .IW(IW)) u_pick (
        .i_req    (bus.req),
        .i_last   (r_last),
        .o_winner (w_winner),
        .o_valid  (w_pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_last  <= IW'(N - 1);
            r_gnt   <= '0;
            r_done  <= '0;
            r_y     <= '0;
            r_busy  <= 1'b0;
            r_start <= 1'b0;
            r_mul_a <= '0;
            r_mul_b <= '0;
        end else begin
            r_state <= w_state_next;
            r_last  <= w_last_next;
            r_gnt   <= w_gnt_next;
            r_done  <= w_done_next;
            r_y     <= w_y_next;
            r_busy  <= w_busy_next;
            r_start <= w_start_next;
            r_mul_a <= w_mul_a_next;
            r_mul_b <= w_mul_b_next;
        end
    end

    // r_last doubles as the owner of the transaction in flight
    always_comb begin
        w_state_next = r_state;
        w_last_next  = r_last;
        w_gnt_next   = '0;
        w_done_next  = '0;
        w_y_next     = r_y;
        w_start_next = 1'b0;
        w_mul_a_next = r_mul_a;
        w_mul_b_next = r_mul_b;
        case (r_state)
            IDLE: begin
                if (w_pick_valid && !bus.mul_busy) begin
                    w_state_next = START;
                    w_last_next  = w_winner;
                    w_gnt_next   = {{(N-1){1'b0}}, 1'b1} << w_winner;
                    w_start_next = 1'b1;
                    w_mul_a_next = w_a[w_winner];
                    w_mul_b_next = w_b[w_winner];
                end
            end
            START: w_state_next = RUN;
            RUN: begin
                if (!bus.mul_busy) begin
                    w_state_next = IDLE;
                    w_y_next     = bus.mul_y;
                    w_done_next  = {{(N-1){1'b0}}, 1'b1} << r_last;
                end
            end
            default: w_state_next = IDLE;
        endcase
        w_busy_next = (w_state_next != IDLE);
    end

    assign bus.gnt       = r_gnt;
    assign bus.done      = r_done;
    assign bus.y         = r_y;
    assign bus.busy      = r_busy;
    assign bus.mul_start = r_start;
    assign bus.mul_a     = r_mul_a;
    assign bus.mul_b     = r_mul_b;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed scenarios plus random traffic against a cycle-level scoreboard.
module tb_mult_arbiter;

    localparam int N  = 2;
    localparam int W  = 8;
    localparam int PW = 2 * W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_arbiter_if #(.N(N), .W(W)) mif ();
    mult_arbiter #(.N(N), .W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(mif));

    logic [N-1:0]  req_r = '0;
    logic [W-1:0]  a_r [N];
    logic [W-1:0]  b_r [N];
    logic          ext_busy = 1'b0;
    logic          mb_busy  = 1'b0;
    logic [PW-1:0] mb_y     = '0;
    logic [PW-1:0] mb_prod  = '0;
    int            mb_cnt   = 0;
    int            mul_lat  = 3;

    int n_vec = 0;
    int n_err = 0;

    always_comb begin
        mif.req    = req_r;
        mif.a_flat = '0;
        mif.b_flat = '0;
        for (int i = 0; i < N; i++) begin
            mif.a_flat[i*W +: W] = a_r[i];
            mif.b_flat[i*W +: W] = b_r[i];
        end
        mif.mul_busy = mb_busy | ext_busy;
        mif.mul_y    = mb_y;
    end

    // External multiplier: busy from the edge after the start pulse, junk on mul_y while busy
    always @(posedge clk) begin
        if (mb_busy) begin
            if (mb_cnt <= 1) begin
                mb_busy <= 1'b0;
                mb_y    <= mb_prod;
            end else begin
                mb_cnt <= mb_cnt - 1;
                mb_y   <= PW'($urandom);
            end
        end else if (mif.mul_start) begin
            mb_busy <= 1'b1;
            mb_cnt  <= mul_lat;
            mb_prod <= PW'(mif.mul_a) * PW'(mif.mul_b);
            mb_y    <= PW'($urandom);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: requester of the transaction in flight and its product
    bit          m_idle = 1'b1;
    int          m_last = N - 1;
    int          m_since = 0;
    int          pend_w = 0;
    logic [31:0] pend_p = '0;
    logic [31:0] last_y = '0;

    logic [N-1:0] c_req;
    logic [W-1:0] c_a [N];
    logic [W-1:0] c_b [N];
    logic         c_mb;
    bit           c_idle;
    bit           c_run;

    function automatic int rr(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic mon_step();
        logic [N-1:0] exp_g;
        logic [N-1:0] exp_d;
        int           w;
        exp_d = '0;
        if (c_run && !c_mb) exp_d = N'(1) << pend_w;
        chk("done", mif.done, exp_d);
        if (exp_d != 0) begin
            last_y = pend_p;
            m_idle = 1'b1;
        end
        chk("y_hold", mif.y, last_y);
        exp_g = '0;
        w     = 0;
        if (c_idle && c_req != 0 && !c_mb) begin
            w     = rr(c_req, m_last);
            exp_g = N'(1) << w;
        end
        chk("gnt", mif.gnt, exp_g);
        chk("mul_start", mif.mul_start, exp_g != 0);
        if (exp_g != 0) begin
            chk("mul_a", mif.mul_a, c_a[w]);
            chk("mul_b", mif.mul_b, c_b[w]);
            m_last  = w;
            m_idle  = 1'b0;
            m_since = 0;
            pend_w  = w;
            pend_p  = c_a[w] * c_b[w];
        end else if (!m_idle) begin
            m_since++;
        end
        chk("busy", mif.busy, !m_idle);
        if (!m_idle && m_since > 200) begin
            chk("run_timeout", m_since, 0);
            m_idle = 1'b1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        c_req  = req_r;
        c_a    = a_r;
        c_b    = b_r;
        c_mb   = mif.mul_busy;
        c_idle = m_idle;
        c_run  = !m_idle && m_since >= 1;
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) mon_step();
    end

    task automatic chk_zero(input string p);
        chk({p, "_gnt"},   mif.gnt, 0);
        chk({p, "_done"},  mif.done, 0);
        chk({p, "_start"}, mif.mul_start, 0);
        chk({p, "_busy"},  mif.busy, 0);
        chk({p, "_mul_a"}, mif.mul_a, 0);
        chk({p, "_mul_b"}, mif.mul_b, 0);
        chk({p, "_y"},     mif.y, 0);
    endtask

    task automatic release_reset(input logic [N-1:0] r);
        @(negedge clk);
        #2;
        m_idle  = 1'b1;
        m_last  = N - 1;
        m_since = 0;
        last_y  = '0;
        req_r   = r;
        rst_n   = 1'b1;
    endtask

    task automatic wait_gnt(input string tag, output logic [N-1:0] g);
        g = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mif.gnt != 0) begin
                g = mif.gnt;
                return;
            end
        end
        chk({tag, "_gnt_timeout"}, 0, 1);
    endtask

    task automatic wait_done(input string tag, output logic [N-1:0] d, output logic [PW-1:0] yv);
        d  = '0;
        yv = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mif.done != 0) begin
                d  = mif.done;
                yv = mif.y;
                return;
            end
        end
        chk({tag, "_done_timeout"}, 0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0]  g;
        logic [N-1:0]  d;
        logic [PW-1:0] yv;
        int            exp_w;
        int            seen;
        for (int i = 0; i < N; i++) begin
            a_r[i] = '0;
            b_r[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk_zero("rst");

        // Single request: 3*5
        release_reset('0);
        a_r[0] = 8'd3;
        b_r[0] = 8'd5;
        req_r  = 2'b01;
        @(negedge clk);
        chk("t1_gnt_lat", mif.gnt, 2'b01);
        chk("t1_start", mif.mul_start, 1);
        req_r = '0;
        wait_done("t1", d, yv);
        chk("t1_done", d, 2'b01);
        chk("t1_y", yv, 15);
        @(negedge clk);
        chk("t1_busy_after", mif.busy, 0);

        // Contention with both requests held: winners alternate starting after last grant 0
        a_r[0] = 8'd2; b_r[0] = 8'd2;
        a_r[1] = 8'd7; b_r[1] = 8'd9;
        req_r  = 2'b11;
        for (int k = 0; k < 6; k++) begin
            wait_done("t2", d, yv);
            exp_w = (k % 2 == 0) ? 1 : 0;
            chk("t2_done", d, N'(1) << exp_w);
            chk("t2_y", yv, (exp_w == 1) ? 63 : 4);
        end
        req_r = '0;
        repeat (2) @(negedge clk);

        // Max operands; operands disturbed right after the grant
        a_r[0] = 8'd255; b_r[0] = 8'd255;
        req_r  = 2'b01;
        wait_gnt("t3", g);
        chk("t3_gnt", g, 2'b01);
        req_r  = '0;
        a_r[0] = 8'd1; b_r[0] = 8'd1;
        wait_done("t3", d, yv);
        chk("t3_y", yv, 65025);

        // Reset while the multiplier is running
        a_r[0] = 8'd4; b_r[0] = 8'd4;
        req_r  = 2'b01;
        wait_gnt("t4", g);
        req_r = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mif.mul_busy && mif.busy) break;
        end
        chk("t4_in_run", mif.mul_busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("t4_rst");
        repeat (2) @(negedge clk);
        release_reset(2'b11);
        wait_gnt("t4a", g);
        chk("t4_first_gnt", g, 2'b01);
        req_r[0] = 1'b0;
        wait_done("t4a", d, yv);
        chk("t4_y0", yv, 16);
        wait_gnt("t4b", g);
        chk("t4_second_gnt", g, 2'b10);
        req_r[1] = 1'b0;
        wait_done("t4b", d, yv);
        chk("t4_y1", yv, 63);
        repeat (3) @(negedge clk);

        // Multiplier busy from outside while idle
        ext_busy = 1'b1;
        req_r    = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_no_gnt", mif.gnt, 0);
        end
        ext_busy = 1'b0;
        @(negedge clk);
        chk("t5_gnt", mif.gnt, 2'b10);
        req_r = '0;
        wait_done("t5", d, yv);
        chk("t5_y", yv, 63);

        // Request 1 pulsed for one cycle while the arbiter is running
        req_r = 2'b01;
        wait_gnt("t6", g);
        req_r = '0;
        @(negedge clk);
        req_r = 2'b10;
        @(negedge clk);
        req_r = '0;
        wait_done("t6", d, yv);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mif.gnt[1]) seen++;
        end
        chk("t6_no_gnt1", seen, 0);

        // Random traffic: re-requests, withdrawals, operand churn, outside busy, varying latency
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            mul_lat  = $urandom_range(1, 4);
            ext_busy = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < N; i++) begin
                if (mif.gnt[i]) begin
                    req_r[i] = ($urandom_range(0, 3) == 0);
                    a_r[i]   = W'($urandom);
                    b_r[i]   = W'($urandom);
                end else if (!req_r[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        a_r[i]   = W'($urandom);
                        b_r[i]   = W'($urandom);
                        req_r[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 19) == 0) begin
                    req_r[i] = 1'b0;
                end
            end
        end
        req_r    = '0;
        ext_busy = 1'b0;
        repeat (30) @(negedge clk);
        chk("final_idle", mif.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
